split_candidate_gen: RTL and testbench
======================================

// Module: split_candidate_gen
// PURPOSE
//  Candidate-assignment generator that drives split_* constraint checkers.
//  Produces pseudo-random packed variable assignments (xorshift64), offers
//  each over a valid/ready handshake, and consumes the checker's 1-bit x verdict.
//  Stops on the first satisfying candidate or after MAX_TRIES rejections.
//  Sits upstream of the split-checker array in the solver datapath.
// PARAMETERS
//  WIDTH      64        packed candidate width, 1..64 (cand_data = state[WIDTH-1:0])
//  MAX_TRIES  1024      attempts before giving up, 1..65535
//  DFLT_SEED  64'h1     seed used at reset and whenever a zero seed is loaded
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  seed_load      in   1      load seed into PRNG state (IDLE/DONE only)
//  seed           in   64     seed value; 0 is replaced by DFLT_SEED
//  start          in   1      begin a search (IDLE/DONE only)
//  cand_valid     out  1      candidate offered to checker
//  cand_ready     in   1      checker accepts candidate
//  cand_data      out  WIDTH  candidate assignment, stable while cand_valid && !cand_ready
//  verdict_valid  in   1      checker verdict present
//  verdict        in   1      checker x: 1 = satisfied, 0 = rejected
//  busy           out  1      search in progress (ISSUE or WAIT)
//  done           out  1      search finished; held until next start
//  found          out  1      valid with done: 1 = satisfying candidate found
//  found_data     out  WIDTH  satisfying candidate (valid when done && found)
//  tries          out  16     verdicts consumed in current/last search
// BEHAVIOUR
//  Reset: state=IDLE, prng=DFLT_SEED, all outputs 0.
//  PRNG step: s^=s<<13; s^=s>>7; s^=s<<17 (64-bit, bits shifted out discarded).
//  FSM: IDLE, ISSUE, WAIT, DONE.
//   IDLE/DONE: seed_load -> prng<=seed (or DFLT_SEED if 0). start -> step prng,
//     tries<=0, done<=0, found<=0, ->ISSUE. start and seed_load in the same
//     cycle: seed is loaded first, then stepped once (both in that one cycle).
//   ISSUE: cand_valid=1, cand_data=prng[WIDTH-1:0]. cand_valid&&cand_ready -> WAIT.
//     verdict_valid ignored in ISSUE.
//   WAIT: cand_valid=0. On verdict_valid: tries<=tries+1;
//     verdict=1 -> found<=1, found_data<=cand_data, done<=1, ->DONE;
//     verdict=0 and tries+1==MAX_TRIES -> found<=0, done<=1, ->DONE;
//     else step prng, ->ISSUE (next candidate offered the following cycle).
//  Latency: start to first cand_valid = 1 cycle; verdict to next cand_valid = 1 cycle.
//  start/seed_load while busy: ignored, no state change.
//  busy = (state==ISSUE||state==WAIT); never high together with done.
//  tries saturates by construction at MAX_TRIES; no wrap.
//  Async reset mid-search: immediate return to IDLE, outputs cleared; pending
//   verdict is discarded.
// TESTING
//  1 Reset, start, cand_ready=1 -> cand_valid 1 cycle after start,
//    cand_data[31:0]=32'h40822041 (DFLT_SEED=1, WIDTH=64).
//  2 Hold cand_ready=0 for 5 cycles -> cand_valid and cand_data stable; tries=0.
//  3 Verdicts 0,0,1 -> three distinct candidates, done=1, found=1, tries=3,
//    found_data equals third cand_data; busy=0.
//  4 MAX_TRIES=4, all verdicts 0 -> done=1, found=0, tries=4; no 5th cand_valid.
//  5 seed_load with seed=0, start -> first cand_data identical to test 1.
//  6 rst_n low while in WAIT -> all outputs 0 asynchronously; start afterwards
//    reproduces test 1 sequence; start during busy has no effect.

Source files
------------

// File: rtl/split_candidate_gen.sv
// ---------------------------------------------------------------------------
// split_candidate_gen : xorshift64 candidate generator for split_* checkers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module split_candidate_gen #(
  parameter int          WIDTH     = 64,
  parameter int          MAX_TRIES = 1024,
  parameter logic [63:0] DFLT_SEED = 64'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [63:0]      seed,
  input  logic             start,
  output logic             cand_valid,
  input  logic             cand_ready,
  output logic [WIDTH-1:0] cand_data,
  input  logic             verdict_valid,
  input  logic             verdict,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] found_data,
  output logic [15:0]      tries
);

  localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [63:0]      r_prng, w_prng_nxt, w_seed_eff;
  logic [15:0]      r_tries, w_tries_nxt, w_tries_inc;
  logic             r_done, w_done_nxt;
  logic             r_found, w_found_nxt;
  logic [WIDTH-1:0] r_found_data, w_found_data_nxt;

  function automatic logic [63:0] xorshift(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  assign w_tries_inc = r_tries + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prng       <= DFLT_SEED;
      r_tries      <= '0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_found_data <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prng       <= w_prng_nxt;
      r_tries      <= w_tries_nxt;
      r_done       <= w_done_nxt;
      r_found      <= w_found_nxt;
      r_found_data <= w_found_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_prng_nxt       = r_prng;
    w_tries_nxt      = r_tries;
    w_done_nxt       = r_done;
    w_found_nxt      = r_found;
    w_found_data_nxt = r_found_data;
    w_seed_eff       = r_prng;
    case (r_state)
      S_IDLE, S_DONE: begin
        // A same-cycle seed_load feeds the start step directly.
        if (seed_load) w_seed_eff = (seed == 64'd0) ? DFLT_SEED : seed;
        w_prng_nxt = w_seed_eff;
        if (start) begin
          w_prng_nxt  = xorshift(w_seed_eff);
          w_tries_nxt = '0;
          w_done_nxt  = 1'b0;
          w_found_nxt = 1'b0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cand_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (verdict_valid) begin
          w_tries_nxt = w_tries_inc;
          if (verdict) begin
            w_found_nxt      = 1'b1;
            w_found_data_nxt = r_prng[WIDTH-1:0];
            w_done_nxt       = 1'b1;
            w_state_nxt      = S_DONE;
          end else if (w_tries_inc == MAX_T) begin
            w_found_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_prng_nxt  = xorshift(r_prng);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Candidate bus reads zero whenever nothing is offered.
  assign cand_valid = (r_state == S_ISSUE);
  assign cand_data  = cand_valid ? r_prng[WIDTH-1:0] : '0;
  assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done       = r_done;
  assign found      = r_found;
  assign found_data = r_found_data;
  assign tries      = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_split_candidate_gen.sv
// ---------------------------------------------------------------------------
// tb_split_candidate_gen : randomized self-checking bench for split_candidate_gen
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_split_candidate_gen;

  localparam int MAXT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [63:0] seed = '0;
  logic        start = 1'b0;
  logic        cand_valid;
  logic        cand_ready = 1'b0;
  logic [63:0] cand_data;
  logic        verdict_valid = 1'b0;
  logic        verdict = 1'b0;
  logic        busy;
  logic        done;
  logic        found;
  logic [63:0] found_data;
  logic [15:0] tries;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] model_prng = 64'd1;

  split_candidate_gen #(.WIDTH(64), .MAX_TRIES(MAXT), .DFLT_SEED(64'h1)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
    .verdict_valid(verdict_valid), .verdict(verdict), .busy(busy), .done(done),
    .found(found), .found_data(found_data), .tries(tries)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time limit exceeded (got hang, need finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] s);
    logic [63:0] a, b;
    a = s ^ (s << 13);
    b = a ^ (a >> 7);
    return b ^ (b << 17);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cand_valid"}, cand_valid, 0);
    chk({tag, "_cand_data"}, cand_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_found_data"}, found_data, 0);
    chk({tag, "_tries"}, tries, 0);
  endtask

  task automatic do_start(input bit load, input logic [63:0] s);
    seed_load = load; seed = s; start = 1'b1;
    tick;
    start = 1'b0; seed_load = 1'b0;
    if (load) model_prng = (s == 64'd0) ? 64'd1 : s;
    model_prng = step(model_prng);
  endtask

  task automatic do_load(input logic [63:0] s);
    seed_load = 1'b1; seed = s;
    tick;
    seed_load = 1'b0;
    model_prng = (s == 64'd0) ? 64'd1 : s;
    chk("load_idle_valid", cand_valid, 0);
  endtask

  // Drives one whole search from the ISSUE state until done.
  task automatic run_search(input bit use_pat, input logic [3:0] pat);
    int n;
    bit fin, v;
    logic [63:0] cur, prev;
    n = 0; fin = 0; prev = '0;
    while (!fin) begin
      chk("cand_valid", cand_valid, 1);
      chk("cand_data", cand_data, model_prng);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("tries_issue", tries, 64'(n));
      cur = model_prng;
      if (use_pat && n > 0) chk("distinct", 64'(cur != prev), 1);
      repeat ($urandom_range(0, 2)) begin
        cand_ready = 1'b0;
        verdict_valid = 1'($urandom_range(0, 1));
        verdict = 1'b1;
        start = 1'($urandom_range(0, 1));
        seed_load = start;
        seed = {$urandom, $urandom};
        tick;
        start = 1'b0; seed_load = 1'b0;
        chk("hold_valid", cand_valid, 1);
        chk("hold_data", cand_data, cur);
        chk("hold_done", done, 0);
      end
      verdict_valid = 1'b0; verdict = 1'b0; cand_ready = 1'b1;
      tick;
      cand_ready = 1'b0;
      chk("wait_valid", cand_valid, 0);
      chk("wait_busy", busy, 1);
      repeat ($urandom_range(0, 2)) begin
        tick;
        chk("wait_idle_valid", cand_valid, 0);
      end
      v = use_pat ? pat[n] : ($urandom_range(0, 2) == 0);
      verdict_valid = 1'b1; verdict = v;
      tick;
      verdict_valid = 1'b0; verdict = 1'b0;
      n++;
      chk("tries", tries, 64'(n));
      if (v) begin
        chk("found_done", done, 1);
        chk("found", found, 1);
        chk("found_data", found_data, cur);
        chk("found_busy", busy, 0);
        fin = 1;
      end else if (n == MAXT) begin
        chk("giveup_done", done, 1);
        chk("giveup_found", found, 0);
        chk("giveup_busy", busy, 0);
        fin = 1;
      end else begin
        model_prng = step(model_prng);
      end
      prev = cur;
    end
    repeat (2) begin
      tick;
      chk("post_valid", cand_valid, 0);
      chk("post_done", done, 1);
      chk("post_tries", tries, 64'(n));
    end
  endtask

  initial begin
    logic [63:0] first;
    logic [63:0] held;
    tick; tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk_all_zero("idle");

    // First candidate from the default seed.
    do_start(0, '0);
    chk("first_valid", cand_valid, 1);
    first = cand_data;
    chk("first_data_lo", {32'd0, first[31:0]}, 64'h40822041);

    // Backpressure: candidate held stable.
    held = cand_data;
    repeat (5) begin
      tick;
      chk("bp_valid", cand_valid, 1);
      chk("bp_data", cand_data, held);
      chk("bp_tries", tries, 0);
    end

    // Verdicts 0,0,1.
    run_search(1, 4'b0100);

    // All rejects give up at MAX_TRIES.
    do_start(0, '0);
    run_search(1, 4'b0000);

    // Zero seed reloads the default.
    do_start(1, 64'd0);
    chk("zero_seed_first", cand_data, first);
    run_search(0, 4'b0000);

    // Asynchronous reset while waiting for a verdict.
    do_start(0, '0);
    cand_ready = 1'b1;
    tick;
    cand_ready = 1'b0;
    chk("pre_rst_wait", cand_valid, 0);
    verdict_valid = 1'b1; verdict = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick; tick;
    verdict_valid = 1'b0; verdict = 1'b0;
    rst_n = 1'b1;
    model_prng = 64'd1;
    tick;
    chk_all_zero("after_rst");
    do_start(0, '0);
    chk("rst_restart", cand_data, first);
    run_search(0, 4'b0000);

    // Randomized searches with random seeds.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0: do_start(1, ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom});
        1: begin
          do_load({$urandom, $urandom});
          do_start(0, '0);
        end
        default: do_start(0, '0);
      endcase
      run_search(0, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
